decode_stage: RTL and testbench

- Registered RV32I instruction-decode stage with an optional M-extension decode path.
- Accepts fetched instructions over a valid/ready handshake and decodes control fields, register indices and a sign-extended immediate.
- Queues decoded entries in a small FIFO toward the execute stage, and supports pipeline flush and illegal-instruction reporting.
- Sits between the fetch unit and the execute/ALU stage.

---
 rtl/decode_stage_if.sv | 57 +++++
 rtl/decode_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for decode_stage.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid and payload stable until
// the transfer. The consumer may move ready freely. decode_stage derives
// in_ready and out_valid from registered state only.
//
// Ports:
//   in_valid/in_ready/in_instr/in_pc    fetch -> decode instruction channel
//   out_valid/out_ready/out_*           decode -> execute decoded-entry channel
// Modports: master = fetch/execute environment, slave = decode_stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic [3:0]      out_alu_type;
  logic [2:0]      out_btype;
  logic [1:0]      out_pc_src;
  logic            out_pc_to_reg_src;
  logic            out_mem_write;
  logic            out_mem_read;
  logic            out_rd_src;
  logic            out_mem_to_reg_src;
  logic            out_alu_src;
  logic            out_reg_write;
  logic            out_muldiv;
  logic [2:0]      out_data_size;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_imm_type, out_alu_type, out_btype, out_pc_src, out_pc_to_reg_src,
           out_mem_write, out_mem_read, out_rd_src, out_mem_to_reg_src,
           out_alu_src, out_reg_write, out_muldiv, out_data_size, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_imm_type, out_alu_type, out_btype, out_pc_src, out_pc_to_reg_src,
           out_mem_write, out_mem_read, out_rd_src, out_mem_to_reg_src,
           out_alu_src, out_reg_write, out_muldiv, out_data_size, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage (optional M decode) with an
// output FIFO toward execute, flush and illegal-instruction counting.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   flush          drop all queued entries and any same-cycle input
//   bus            decode_stage_if.slave (instruction in, decoded entry out)
//   illegal_count  saturating count of accepted illegal instructions
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter bit SUPPORT_M = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] illegal_count
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
                         IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic [3:0]      alu_type;
    logic [2:0]      btype;
    logic [1:0]      pc_src;
    logic            pc_to_reg_src;
    logic            mem_write;
    logic            mem_read;
    logic            rd_src;
    logic            mem_to_reg_src;
    logic            alu_src;
    logic            reg_write;
    logic            muldiv;
    logic [2:0]      data_size;
    logic            illegal;
  } entry_t;

  // ---------------- combinational decode ----------------
  logic [31:0]        w_ins;
  logic [4:0]         w_op;
  logic [2:0]         w_f3;
  logic [6:0]         w_f7;
  logic               w_bad;
  logic signed [31:0] w_imm32;
  entry_t             w_dec;
  entry_t             w_entry;

  assign w_ins = bus.in_instr;
  assign w_op  = w_ins[6:2];
  assign w_f3  = w_ins[14:12];
  assign w_f7  = w_ins[31:25];

  always_comb begin
    w_dec   = '0;
    w_bad   = 1'b0;
    w_imm32 = '0;
    if (w_ins[1:0] != 2'b11) begin
      w_bad = 1'b1;
    end else begin
      unique case (w_op)
        5'b01100: begin
          w_dec.alu_src   = 1'b1;
          w_dec.reg_write = 1'b1;
          if (w_f7 == 7'b0000001) begin
            w_bad          = !SUPPORT_M;
            w_dec.muldiv   = 1'b1;
            w_dec.alu_type = {1'b0, w_f3};
          end else begin
            w_dec.alu_type = {w_f7[5], w_f3};
          end
        end
        5'b00100: begin
          w_dec.imm_type  = IMM_I;
          // Only the shift-right group uses funct7[5] (srai vs srli).
          w_dec.alu_type  = (w_f3 == 3'b101) ? {w_f7[5], w_f3} : {1'b0, w_f3};
          w_dec.reg_write = 1'b1;
        end
        5'b00000: begin
          w_dec.imm_type       = IMM_I;
          w_dec.mem_read       = 1'b1;
          w_dec.mem_to_reg_src = 1'b1;
          w_dec.reg_write      = 1'b1;
          w_dec.data_size      = w_f3;
          w_bad                = (w_f3 == 3'd3) || (w_f3[2:1] == 2'b11);
        end
        5'b01000: begin
          w_dec.imm_type  = IMM_S;
          w_dec.mem_write = 1'b1;
          w_dec.data_size = w_f3;
          w_bad           = (w_f3 > 3'd2);
        end
        5'b11000: begin
          w_dec.imm_type = IMM_B;
          w_dec.alu_type = 4'hF;
          w_dec.btype    = w_f3;
          w_dec.pc_src   = 2'd3;
          w_bad          = (w_f3[2:1] == 2'b01);
        end
        5'b11001: begin
          w_dec.imm_type  = IMM_I;
          w_dec.pc_src    = 2'd2;
          w_dec.rd_src    = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        5'b11011: begin
          w_dec.imm_type  = IMM_J;
          w_dec.alu_type  = 4'hF;
          w_dec.pc_src    = 2'd1;
          w_dec.rd_src    = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        5'b00101: begin
          w_dec.imm_type      = IMM_U;
          w_dec.alu_type      = 4'hF;
          w_dec.pc_to_reg_src = 1'b1;
          w_dec.rd_src        = 1'b1;
          w_dec.reg_write     = 1'b1;
        end
        5'b01101: begin
          w_dec.imm_type  = IMM_U;
          w_dec.alu_type  = 4'hF;
          w_dec.reg_write = 1'b1;
        end
        default: w_bad = 1'b1;
      endcase
    end

    unique case (w_dec.imm_type)
      IMM_I:   w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
      IMM_S:   w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      IMM_B:   w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      IMM_U:   w_imm32 = {w_ins[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
    // Signed size cast sign-extends the 32-bit immediate to XLEN.
    w_dec.imm = XLEN'(w_imm32);

    w_dec.pc  = bus.in_pc;
    w_dec.rd  = w_ins[11:7];
    w_dec.rs1 = w_ins[19:15];
    w_dec.rs2 = w_ins[24:20];

    // Illegal entries keep only pc and register indices.
    if (w_bad) begin
      w_entry         = '0;
      w_entry.pc      = w_dec.pc;
      w_entry.rd      = w_dec.rd;
      w_entry.rs1     = w_dec.rs1;
      w_entry.rs2     = w_dec.rs2;
      w_entry.illegal = 1'b1;
    end else begin
      w_entry = w_dec;
    end
  end

  // ---------------- output FIFO ----------------
  entry_t           r_mem [BUF_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_ill_cnt;
  logic             w_push;
  logic             w_pop;
  entry_t           w_head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign bus.in_ready  = (r_count < CW'(BUF_DEPTH));
  assign bus.out_valid = (r_count != '0);
  assign w_push        = bus.in_valid & bus.in_ready & ~flush & ~rst;
  assign w_pop         = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ill_cnt <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_push && w_entry.illegal && (r_ill_cnt != '1))
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head        = bus.out_valid ? r_mem[r_rd_ptr] : '0;
  assign illegal_count = r_ill_cnt;

  assign bus.out_pc             = w_head.pc;
  assign bus.out_rd             = w_head.rd;
  assign bus.out_rs1            = w_head.rs1;
  assign bus.out_rs2            = w_head.rs2;
  assign bus.out_imm            = w_head.imm;
  assign bus.out_imm_type       = w_head.imm_type;
  assign bus.out_alu_type       = w_head.alu_type;
  assign bus.out_btype          = w_head.btype;
  assign bus.out_pc_src         = w_head.pc_src;
  assign bus.out_pc_to_reg_src  = w_head.pc_to_reg_src;
  assign bus.out_mem_write      = w_head.mem_write;
  assign bus.out_mem_read       = w_head.mem_read;
  assign bus.out_rd_src         = w_head.rd_src;
  assign bus.out_mem_to_reg_src = w_head.mem_to_reg_src;
  assign bus.out_alu_src        = w_head.alu_src;
  assign bus.out_reg_write      = w_head.reg_write;
  assign bus.out_muldiv         = w_head.muldiv;
  assign bus.out_data_size      = w_head.data_size;
  assign bus.out_illegal        = w_head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives two decode_stage instances with identical stimulus,
// one without M decode (16-bit illegal counter) and one with M decode and a
// 3-bit counter so saturation is reachable. A queue of accepted {pc,instr}
// plus a table-driven decoder predicts every output each cycle.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_A = 16;
  localparam int CNT_B = 3;
  localparam int VW    = 103;

  localparam logic [4:0] OPS [10] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                      5'b11001, 5'b11011, 5'b00101, 5'b01101, 5'b11111};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  decode_stage_if #(.XLEN(XLEN)) bus_a ();
  decode_stage_if #(.XLEN(XLEN)) bus_b ();
  logic [CNT_A-1:0] ill_a;
  logic [CNT_B-1:0] ill_b;

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_instr  = in_instr;
  assign bus_a.in_pc     = in_pc;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_instr  = in_instr;
  assign bus_b.in_pc     = in_pc;
  assign bus_b.out_ready = out_ready;

  decode_stage #(.XLEN(XLEN), .BUF_DEPTH(DEPTH), .SUPPORT_M(1'b0), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_a), .illegal_count(ill_a));
  decode_stage #(.XLEN(XLEN), .BUF_DEPTH(DEPTH), .SUPPORT_M(1'b1), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_b), .illegal_count(ill_b));

  logic [VW-1:0] obs_a, obs_b;
  assign obs_a = {bus_a.out_pc, bus_a.out_rd, bus_a.out_rs1, bus_a.out_rs2, bus_a.out_imm,
                  bus_a.out_imm_type, bus_a.out_alu_type, bus_a.out_btype, bus_a.out_pc_src,
                  bus_a.out_pc_to_reg_src, bus_a.out_mem_write, bus_a.out_mem_read,
                  bus_a.out_rd_src, bus_a.out_mem_to_reg_src, bus_a.out_alu_src,
                  bus_a.out_reg_write, bus_a.out_muldiv, bus_a.out_data_size, bus_a.out_illegal};
  assign obs_b = {bus_b.out_pc, bus_b.out_rd, bus_b.out_rs1, bus_b.out_rs2, bus_b.out_imm,
                  bus_b.out_imm_type, bus_b.out_alu_type, bus_b.out_btype, bus_b.out_pc_src,
                  bus_b.out_pc_to_reg_src, bus_b.out_mem_write, bus_b.out_mem_read,
                  bus_b.out_rd_src, bus_b.out_mem_to_reg_src, bus_b.out_alu_src,
                  bus_b.out_reg_write, bus_b.out_muldiv, bus_b.out_data_size, bus_b.out_illegal};

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int  exp_ill_a, exp_ill_b;
  bit  model_valid = 1'b0;
  bit  last_push;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder written from the instruction table.
  function automatic logic [VW-1:0] model(input logic [31:0] ins, input logic [31:0] pc, input bit m);
    logic [2:0] f3;
    logic [6:0] f7;
    int it, alu, bt, ps, ds, imm;
    bit ptr, mw, mr, rds, m2r, as, rw, md, ill;
    f3 = ins[14:12];
    f7 = ins[31:25];
    it = 0; alu = 0; bt = 0; ps = 0; ds = 0; imm = 0;
    ptr = 0; mw = 0; mr = 0; rds = 0; m2r = 0; as = 0; rw = 0; md = 0; ill = 0;
    if (ins[1:0] != 2'b11) ill = 1;
    else begin
      case (ins[6:2])
        5'b01100: begin
          as = 1; rw = 1;
          if (f7 == 7'd1) begin md = 1; alu = int'(f3); ill = !m; end
          else alu = 8 * int'(f7[5]) + int'(f3);
        end
        5'b00100: begin
          it = 1; rw = 1;
          alu = (f3 == 3'd5) ? 8 * int'(f7[5]) + 5 : int'(f3);
        end
        5'b00000: begin
          it = 1; mr = 1; m2r = 1; rw = 1; ds = int'(f3);
          ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
        end
        5'b01000: begin it = 2; mw = 1; ds = int'(f3); ill = (f3 > 2); end
        5'b11000: begin it = 3; alu = 15; bt = int'(f3); ps = 3; ill = (f3 == 2) || (f3 == 3); end
        5'b11001: begin it = 1; ps = 2; rds = 1; rw = 1; end
        5'b11011: begin it = 5; alu = 15; ps = 1; rds = 1; rw = 1; end
        5'b00101: begin it = 4; alu = 15; ptr = 1; rds = 1; rw = 1; end
        5'b01101: begin it = 4; alu = 15; rw = 1; end
        default: ill = 1;
      endcase
    end
    case (it)
      1: imm = int'($signed(ins[31:20]));
      2: imm = int'($signed({ins[31:25], ins[11:7]}));
      3: imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      4: imm = int'(ins[31:12]) * 4096;
      5: imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      default: imm = 0;
    endcase
    if (ill) begin
      it = 0; alu = 0; bt = 0; ps = 0; ds = 0; imm = 0;
      ptr = 0; mw = 0; mr = 0; rds = 0; m2r = 0; as = 0; rw = 0; md = 0;
    end
    return {pc, ins[11:7], ins[19:15], ins[24:20], 32'(imm), 3'(it), 4'(alu), 3'(bt), 2'(ps),
            ptr, mw, mr, rds, m2r, as, rw, md, 3'(ds), ill};
  endfunction

  // One clock: compare at negedge, advance model, return 1 time unit after posedge.
  task automatic cycle();
    bit ready, push, pop;
    logic [VW-1:0] ea, eb, ma;
    @(negedge clk);
    ready = (exp_q.size() < DEPTH);
    if (exp_q.size() > 0) begin
      ea = model(exp_q[0][31:0], exp_q[0][63:32], 1'b0);
      eb = model(exp_q[0][31:0], exp_q[0][63:32], 1'b1);
    end else begin
      ea = '0;
      eb = '0;
    end
    if (model_valid) begin
      chk("in_ready_a", bus_a.in_ready, ready);
      chk("in_ready_b", bus_b.in_ready, ready);
      chk("out_valid_a", bus_a.out_valid, exp_q.size() > 0);
      chk("out_valid_b", bus_b.out_valid, exp_q.size() > 0);
      chk("entry_a", obs_a, ea);
      chk("entry_b", obs_b, eb);
      chk("ill_cnt_a", ill_a, exp_ill_a);
      chk("ill_cnt_b", ill_b, exp_ill_b);
    end
    push = 0;
    if (rst) begin
      exp_q.delete();
      exp_ill_a = 0;
      exp_ill_b = 0;
      model_valid = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      pop  = (exp_q.size() > 0) && out_ready;
      push = in_valid && ready;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({in_pc, in_instr});
        ma = model(in_instr, in_pc, 1'b0);
        if (ma[0] && exp_ill_a < (1 << CNT_A) - 1) exp_ill_a++;
        eb = model(in_instr, in_pc, 1'b1);
        if (eb[0] && exp_ill_b < (1 << CNT_B) - 1) exp_ill_b++;
      end
    end
    last_push = push;
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    r[6:2] = OPS[$urandom_range(0, 9)];
    r[1:0] = 2'b11;
    if (r[6:2] == 5'b01100) begin
      sel = $urandom_range(0, 2);
      r[31:25] = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'h01;
    end
    if ($urandom_range(0, 11) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Present a list of instructions, advancing only when one is accepted.
  task automatic send_list(input logic [31:0] lst[$], input int max_cycles);
    int idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < max_cycles && idx < lst.size(); c++) begin
      in_instr = lst[idx];
      in_pc    = 32'h1000 + 32'(4 * idx);
      cycle();
      if (last_push) idx++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lst[$];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    chk("rst_out_valid", bus_a.out_valid, 1'b0);
    chk("rst_in_ready", bus_a.in_ready, 1'b1);
    chk("rst_ill_cnt", ill_a, 0);
    chk("rst_payload", obs_a, '0);

    // addi x1,x2,-5
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h100;
    cycle();
    in_valid = 1'b0;
    chk("addi_valid", bus_a.out_valid, 1'b1);
    chk("addi_imm", bus_a.out_imm, 32'hFFFFFFFB);
    chk("addi_alu", bus_a.out_alu_type, 4'h0);
    chk("addi_reg_write", bus_a.out_reg_write, 1'b1);
    chk("addi_rs1", bus_a.out_rs1, 5'd2);
    chk("addi_rd", bus_a.out_rd, 5'd1);
    cycle();

    // Four back-to-back with execute stalled, then release.
    out_ready = 1'b0;
    lst = '{32'h002081B3, 32'h402081B3, 32'h0040A183, 32'h0030A223};
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin in_instr = lst[i]; in_pc = 32'h200 + 32'(4 * i); cycle(); end
    chk("stall_in_ready_low", bus_a.in_ready, 1'b0);
    in_instr = lst[2]; in_pc = 32'h208;
    cycle();
    chk("stall_hold_valid", bus_a.out_valid, 1'b1);
    chk("stall_hold_pc", bus_a.out_pc, 32'h200);
    out_ready = 1'b1;
    send_list(lst[2:3], 20);
    repeat (3) cycle();
    chk("stall_drained", bus_a.out_valid, 1'b0);

    // Fill, then keep pushing and popping together.
    out_ready = 1'b0;
    send_list('{32'h0FF12093, 32'h5550C113}, 10);
    in_valid = 1'b1;
    lst = '{32'h4030D093, 32'h123450B7, 32'h00001097, 32'h000100E7, 32'h00208463};
    out_ready = 1'b1;
    send_list(lst, 30);
    repeat (3) cycle();

    // beq then jal
    in_valid = 1'b1; in_instr = 32'h00208463; in_pc = 32'h300;
    cycle();
    chk("beq_btype", bus_a.out_btype, 3'b000);
    chk("beq_pc_src", bus_a.out_pc_src, 2'd3);
    chk("beq_imm", bus_a.out_imm, 32'd8);
    in_instr = 32'h001000EF; in_pc = 32'h304;
    cycle();
    in_valid = 1'b0;
    chk("jal_imm", bus_a.out_imm, 32'h800);
    chk("jal_pc_src", bus_a.out_pc_src, 2'd1);
    chk("jal_rd_src", bus_a.out_rd_src, 1'b1);
    cycle();

    // mul: illegal without M, muldiv with M
    in_valid = 1'b1; in_instr = 32'h02208033; in_pc = 32'h400;
    cycle();
    in_valid = 1'b0;
    chk("mul_illegal_a", bus_a.out_illegal, 1'b1);
    chk("mul_ill_cnt_a", ill_a, 1);
    chk("mul_muldiv_b", bus_b.out_muldiv, 1'b1);
    chk("mul_alu_b", bus_b.out_alu_type, 4'h0);
    chk("mul_illegal_b", bus_b.out_illegal, 1'b0);
    cycle();

    // Flush with two queued entries and an illegal instruction presented.
    out_ready = 1'b0;
    send_list('{32'hFFB10093, 32'h00208463}, 10);
    in_valid = 1'b1; in_instr = 32'h00000000; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", bus_a.out_valid, 1'b0);
    chk("flush_in_ready", bus_a.in_ready, 1'b1);
    chk("flush_ill_cnt", ill_a, 1);
    // Flush with room in the FIFO: same-cycle illegal input must be dropped.
    send_list('{32'h0040A183}, 5);
    in_valid = 1'b1; in_instr = 32'h00000000; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush2_ill_cnt", ill_a, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_no_emerge", bus_a.out_valid, 1'b0);
    end

    // Saturation of the narrow counter.
    in_valid = 1'b1; in_instr = 32'h00000000;
    repeat (10) cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("sat_ill_b", ill_b, 3'd7);
    chk("sat_ill_a", ill_a, 11);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFFFFFC;
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
